// File: rtl/cpu1_memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// The grant is combinational; a read response returns exactly one cycle after acceptance.
module cpu1_memory_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic pend0;
  logic pend1;
  logic grant0;
  logic grant1;
  logic any_grant;
  logic last_grant;
  logic rsp_valid;
  logic rsp_owner;

  assign pend0 = m0_read | m0_write;
  assign pend1 = m1_read | m1_write;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (pend0 && pend1) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = pend0;
        grant1 = pend1;
      end
    end
  end

  assign any_grant = grant0 | grant1;

  // Reset holds both requesters off; otherwise only a pending loser waits.
  assign m0_waitrequest = ~reset_n | (pend0 & ~grant0);
  assign m1_waitrequest = ~reset_n | (pend1 & ~grant1);

  assign mem_address    = grant1 ? m1_address    : m0_address;
  assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = any_grant;
  assign mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
  assign mem_clken      = reset_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_owner  <= 1'b0;
    end else begin
      // A read+write command is a write, so it never produces a response.
      rsp_valid <= (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
      rsp_owner <= grant1;
      if (any_grant) last_grant <= grant1;
    end
  end

  assign m0_readdatavalid = rsp_valid & ~rsp_owner;
  assign m1_readdatavalid = rsp_valid &  rsp_owner;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule
